// File: rtl/cache_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_axi_bridge_pkg
// Purpose : Shared AXI4 burst constants, FSM state encodings and a line
//           address compare helper for the cache line refill/writeback bridge.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cache_axi_bridge_pkg;

  // A 128-bit cache line travels as four 32-bit INCR beats.
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_LINE   = 8'd3;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [3:0] AXI_WSTRB_FULL = 4'hF;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2,
    R_DONE = 2'd3
  } rd_state_e;

  typedef enum logic [2:0] {
    W_IDLE = 3'd0,
    W_AW   = 3'd1,
    W_DATA = 3'd2,
    W_B    = 3'd3,
    W_DONE = 3'd4
  } wr_state_e;

  // Two byte addresses hit the same 16-byte line when their [31:4] bits match.
  function automatic logic same_line(input logic [27:0] a_line, input logic [27:0] b_line);
    return a_line == b_line;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module  : cache_axi_bridge
// Purpose : Cache line refill / writeback engine. Turns 128-bit line read and
//           write requests into 4-beat AXI4 INCR bursts of 32-bit data.
//           Read and write paths are independent FSMs; a read to a line that
//           is being written back waits until the writeback completes.
// Ports   : clk, rst                       - clock, sync active-high reset
//           rd_req/rd_addr/rd_rdy          - line read request handshake
//           ret_valid/ret_data             - refilled line, one-cycle pulse
//           wr_req/wr_addr/wr_data/wr_rdy  - line writeback request handshake
//           wr_valid                       - writeback done, one-cycle pulse
//           ar*/r*                         - AXI4 read address / data channels
//           aw*/w*/b*                      - AXI4 write addr / data / resp channels
// Revision: 1.0 - initial release
// ============================================================================
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         rst,
  // cache read side
  input  logic         rd_req,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [127:0] ret_data,
  // cache write side
  input  logic         wr_req,
  input  logic [31:0]  wr_addr,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         wr_valid,
  // AR channel
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  // R channel
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  // AW channel
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  // W channel
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  // B channel
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  rd_state_e      rd_state_q, rd_state_d;
  logic [1:0]     rd_cnt_q, rd_cnt_d;
  logic [31:0]    araddr_q, araddr_d;
  logic           arvalid_q, arvalid_d;
  logic           rready_q, rready_d;
  logic           ret_valid_q, ret_valid_d;
  logic [127:0]   ret_data_q, ret_data_d;

  wr_state_e      wr_state_q, wr_state_d;
  logic [1:0]     wr_cnt_q, wr_cnt_d;
  logic [31:0]    wr_line_addr_q, wr_line_addr_d;
  logic [127:0]   wr_line_q, wr_line_d;
  logic           awvalid_q, awvalid_d;
  logic           wvalid_q, wvalid_d;
  logic           bready_q, bready_d;
  logic           wr_valid_q, wr_valid_d;

  logic           w_busy;
  logic           w_wr_accept;
  logic           w_rd_hazard;

  // Response IDs/codes, rlast and the line-offset bits carry no control meaning here.
  logic           w_unused;
  assign w_unused = ^{rid, rresp, rlast, bid, bresp, rd_addr[3:0], wr_addr[3:0]};

  // --------------------------------------------------------------------------
  // Request handshakes and read-after-write hazard
  // --------------------------------------------------------------------------
  assign w_busy      = (wr_state_q != W_IDLE);
  assign wr_rdy      = (wr_state_q == W_IDLE);
  assign w_wr_accept = wr_req & wr_rdy;

  // A read must not overtake a writeback of the same line: block it while the
  // write FSM owns that line, and also when that write is being accepted in
  // this very cycle (the write wins the tie).
  assign w_rd_hazard = (w_busy      & same_line(rd_addr[31:4], wr_line_addr_q[31:4])) |
                       (w_wr_accept & same_line(rd_addr[31:4], wr_addr[31:4]));
  assign rd_rdy      = (rd_state_q == R_IDLE) & ~w_rd_hazard;

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_cnt_d    = rd_cnt_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    ret_valid_d = 1'b0;
    ret_data_d  = ret_data_q;
    case (rd_state_q)
      R_IDLE: begin
        if (rd_req && rd_rdy) begin
          araddr_d   = {rd_addr[31:4], 4'h0};
          arvalid_d  = 1'b1;
          rd_cnt_d   = 2'd0;
          rd_state_d = R_AR;
        end
      end
      R_AR: begin
        if (arready) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        // The beat counter alone decides when the line is complete.
        if (rvalid && rready_q) begin
          ret_data_d[{rd_cnt_q, 5'd0} +: 32] = rdata;
          rd_cnt_d = rd_cnt_q + 2'd1;
          if (rd_cnt_q == 2'd3) begin
            rready_d    = 1'b0;
            ret_valid_d = 1'b1;
            rd_state_d  = R_DONE;
          end
        end
      end
      R_DONE: begin
        rd_state_d = R_IDLE;
      end
      default: begin
        rd_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q  <= R_IDLE;
      rd_cnt_q    <= 2'd0;
      araddr_q    <= 32'd0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      ret_valid_q <= 1'b0;
      ret_data_q  <= 128'd0;
    end else begin
      rd_state_q  <= rd_state_d;
      rd_cnt_q    <= rd_cnt_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      ret_valid_q <= ret_valid_d;
      ret_data_q  <= ret_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  always_comb begin
    wr_state_d     = wr_state_q;
    wr_cnt_d       = wr_cnt_q;
    wr_line_addr_d = wr_line_addr_q;
    wr_line_d      = wr_line_q;
    awvalid_d      = awvalid_q;
    wvalid_d       = wvalid_q;
    bready_d       = bready_q;
    wr_valid_d     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (w_wr_accept) begin
          wr_line_addr_d = {wr_addr[31:4], 4'h0};
          wr_line_d      = wr_data;
          awvalid_d      = 1'b1;
          wr_cnt_d       = 2'd0;
          wr_state_d     = W_AW;
        end
      end
      W_AW: begin
        if (awready) begin
          awvalid_d  = 1'b0;
          wvalid_d   = 1'b1;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wready) begin
          wr_cnt_d = wr_cnt_q + 2'd1;
          if (wr_cnt_q == 2'd3) begin
            wvalid_d   = 1'b0;
            bready_d   = 1'b1;
            wr_state_d = W_B;
          end
        end
      end
      W_B: begin
        if (bvalid) begin
          bready_d   = 1'b0;
          wr_valid_d = 1'b1;
          wr_state_d = W_DONE;
        end
      end
      W_DONE: begin
        wr_state_d = W_IDLE;
      end
      default: begin
        wr_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q     <= W_IDLE;
      wr_cnt_q       <= 2'd0;
      wr_line_addr_q <= 32'd0;
      wr_line_q      <= 128'd0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      wr_valid_q     <= 1'b0;
    end else begin
      wr_state_q     <= wr_state_d;
      wr_cnt_q       <= wr_cnt_d;
      wr_line_addr_q <= wr_line_addr_d;
      wr_line_q      <= wr_line_d;
      awvalid_q      <= awvalid_d;
      wvalid_q       <= wvalid_d;
      bready_q       <= bready_d;
      wr_valid_q     <= wr_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  assign ret_valid = ret_valid_q;
  assign ret_data  = ret_data_q;
  assign wr_valid  = wr_valid_q;

  assign arid      = RD_ID;
  assign araddr    = araddr_q;
  assign arlen     = AXI_LEN_LINE;
  assign arsize    = AXI_SIZE_WORD;
  assign arburst   = AXI_BURST_INCR;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

  assign awid      = WR_ID;
  assign awaddr    = wr_line_addr_q;
  assign awlen     = AXI_LEN_LINE;
  assign awsize    = AXI_SIZE_WORD;
  assign awburst   = AXI_BURST_INCR;
  assign awvalid   = awvalid_q;

  // Word i of the latched line goes out as beat i.
  assign wdata     = wr_line_q[{wr_cnt_q, 5'd0} +: 32];
  assign wstrb     = AXI_WSTRB_FULL;
  assign wlast     = wvalid_q & (wr_cnt_q == 2'd3);
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;

endmodule
`default_nettype wire
